dmr_retry_buffer: RTL and testbench
===================================

DMR_RETRY_BUFFER -- requirements
Module: dmr_retry_buffer

Interface
REQ-001 Parameter DataType, default logic [7:0]: payload type.
REQ-002 Parameter IDSize, default 4: transaction ID width; table depth N = 2**IDSize.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 data_i  in  DataType  upstream payload.
REQ-006 valid_i  in  1  upstream valid.
REQ-007 ready_o  out  1  upstream ready.
REQ-008 data_o  out  DataType  payload toward the time-DMR start stage.
REQ-009 id_o  out  IDSize  ID of the issued transaction.
REQ-010 valid_o  out  1  downstream valid.
REQ-011 ready_i  in  1  downstream ready.
REQ-012 fb_valid_i  in  1  feedback valid from the time-DMR end stage output.
REQ-013 fb_id_i  in  IDSize  ID of the completed transaction.
REQ-014 fb_needs_retry_i  in  1  1 = DMR mismatch, transaction must be replayed.
REQ-015 fb_ready_o  out  1  feedback ready; tied 1.

Function
REQ-016 The block SHALL hold a table of N entries {data, busy}, a free-running issue counter next_id (IDSize bits), and a retry FIFO of IDs, depth N.
REQ-017 New transaction: eligible when valid_i=1, table[next_id].busy=0, and the FIFO is empty; it is presented with id_o=next_id and data_o=data_i, zero latency.
REQ-018 Retry transaction: eligible when the FIFO is non-empty; it is presented with id_o=FIFO head and data_o=table[head].data.
REQ-019 Priority: a retry SHALL win over a new transaction.
REQ-020 valid_o SHALL be 1 when a retry or new transaction is eligible; ready_o = ready_i AND new transaction selected.
REQ-021 Selection lock: if valid_o=1 and ready_i=0, the selection (source, ID, data) SHALL be registered and held unchanged until the handshake completes; a retry arriving meanwhile does not pre-empt a presented new transaction.
REQ-022 New handshake (valid_o and ready_i, new source): table[next_id] <= {data_i, busy=1}; next_id increments modulo N (wraps N-1 -> 0).
REQ-023 Retry handshake: the FIFO pops; the entry stays busy; the ID is unchanged.
REQ-024 Feedback handshake with fb_needs_retry_i=0: table[fb_id_i].busy <= 0.
REQ-025 Feedback handshake with fb_needs_retry_i=1: fb_id_i is pushed to the FIFO; the pushed entry is poppable no earlier than the next cycle (no bypass).
REQ-026 A simultaneous push and pop SHALL both take effect; the FIFO count stays unchanged.
REQ-027 FIFO overflow cannot occur; at most N IDs are busy.
REQ-028 Feedback for an ID whose entry is not busy SHALL be ignored; no state changes.
REQ-029 Table full (table[next_id].busy=1): ready_o=0 and valid_o is driven by retries only.
REQ-030 Feedback freeing next_id in the same cycle as valid_i: the slot becomes usable the next cycle.

Reset
REQ-031 While rst_ni=0: all busy bits 0, next_id=0, FIFO empty, lock cleared; valid_o=0, ready_o=0; fb_ready_o=1.
REQ-032 Reset asserted mid-transaction SHALL discard all outstanding and pending-retry transactions without emitting any output.
REQ-033 Table data contents need not be reset.

Verification
REQ-034 Pass-through: ready_i=1, stream 0x11,0x22,0x33, each fed back with needs_retry=0 -> id_o=0,1,2, data_o equals input, ready_o=1 every cycle.
REQ-035 Retry: issue 0xA5 (id 0), feedback id 0 with needs_retry=1 -> next cycle valid_o=1, id_o=0, data_o=0xA5, ready_o=0 with valid_i=1 pending.
REQ-036 Full: N issues without feedback -> ready_o=0; feedback id 0 with needs_retry=0 -> next cycle new issue with id_o=0 (wrap).
REQ-037 Lock: new 0x5A presented with ready_i=0, retry for id 3 arrives -> id_o and data_o stay 0x5A until the handshake; the retry for id 3 is issued next.
REQ-038 Stale feedback: feedback id 7 with needs_retry=1 while id 7 is not busy -> FIFO stays empty, no output.
REQ-039 Reset: pulse rst_ni low with 3 IDs busy and 1 queued -> valid_o=0; the first post-reset issue has id_o=0.

Source files
------------

// File: rtl/dmr_retry_buffer.sv
// dmr_retry_buffer: issues upstream transactions toward a time-DMR stage,
// keeps a copy of every in-flight payload, and replays transactions that
// the DMR end stage reports as mismatched. Replays take priority over new
// traffic. A presented transaction stays frozen until it is accepted.
module dmr_retry_buffer #(
   parameter type DataType = logic [7:0],
   parameter int  IDSize   = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  DataType           data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output DataType           data_o,
   output logic [IDSize-1:0] id_o,
   output logic              valid_o,
   input  logic              ready_i,
   input  logic              fb_valid_i,
   input  logic [IDSize-1:0] fb_id_i,
   input  logic              fb_needs_retry_i,
   output logic              fb_ready_o
);

   localparam int N = 2 ** IDSize;

   typedef logic [IDSize-1:0] id_t;
   typedef logic [IDSize:0]   cnt_t;

   localparam id_t  ID_ONE  = id_t'(1);
   localparam cnt_t CNT_ONE = cnt_t'(1);

   typedef enum logic {
      SEL_OPEN,
      SEL_HELD
   } sel_state_t;

   // In-flight table and issue counter
   logic [N-1:0] busy;
   DataType      table_data [N];
   id_t          next_id;

   // Retry FIFO of IDs
   id_t          fifo_mem [N];
   id_t          rd_ptr;
   id_t          wr_ptr;
   cnt_t         fifo_cnt;

   // Selection lock
   sel_state_t   sel_q;
   sel_state_t   sel_d;
   logic         held_retry;
   id_t          held_id;
   DataType      held_data;

   // Combinational selection and handshake decode
   logic         fifo_empty;
   id_t          head;
   logic         retry_elig;
   logic         new_elig;
   logic         pick_valid;
   logic         pick_retry;
   id_t          pick_id;
   DataType      pick_data;
   logic         out_valid;
   logic         hs;
   logic         issue;
   logic         pop;
   logic         fb_hit;
   logic         push;
   logic         release_id;
   logic         capture;

   // Pick the transaction to present: a held selection first, then retries, then new data
   always_comb begin
      fifo_empty = (fifo_cnt == '0);
      head       = fifo_mem[rd_ptr];
      retry_elig = !fifo_empty;
      new_elig   = valid_i && !busy[next_id] && fifo_empty;
      pick_valid = 1'b0;
      pick_retry = 1'b0;
      pick_id    = next_id;
      pick_data  = data_i;
      if (sel_q == SEL_HELD) begin
         pick_valid = 1'b1;
         pick_retry = held_retry;
         pick_id    = held_id;
         pick_data  = held_data;
      end else if (retry_elig) begin
         pick_valid = 1'b1;
         pick_retry = 1'b1;
         pick_id    = head;
         pick_data  = table_data[head];
      end else if (new_elig) begin
         pick_valid = 1'b1;
      end
      // Outputs are forced quiet while reset is held, even with upstream valid high
      out_valid  = pick_valid && rst_ni;
      hs         = out_valid && ready_i;
      issue      = hs && !pick_retry;
      pop        = hs && pick_retry;
      // Feedback for an ID that is not in flight is dropped
      fb_hit     = fb_valid_i && busy[fb_id_i];
      push       = fb_hit && fb_needs_retry_i;
      release_id = fb_hit && !fb_needs_retry_i;
      capture    = (sel_q == SEL_OPEN) && out_valid && !ready_i;
   end

   // Lock next-state: freeze a stalled presentation until downstream accepts it
   always_comb begin
      sel_d = sel_q;
      case (sel_q)
         SEL_OPEN: if (capture) sel_d = SEL_HELD;
         SEL_HELD: if (ready_i) sel_d = SEL_OPEN;
         default:  sel_d = SEL_OPEN;
      endcase
   end

   assign data_o     = pick_data;
   assign id_o       = pick_id;
   assign valid_o    = out_valid;
   assign ready_o    = ready_i && out_valid && !pick_retry;
   assign fb_ready_o = 1'b1;

   // Control state: busy bits, issue counter, FIFO pointers and lock state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy     <= '0;
         next_id  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
         sel_q    <= SEL_OPEN;
      end else begin
         sel_q <= sel_d;
         if (issue) begin
            busy[next_id] <= 1'b1;
            next_id       <= next_id + ID_ONE;
         end
         if (release_id) begin
            busy[fb_id_i] <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + ID_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ID_ONE;
         end
         if (push && !pop) begin
            fifo_cnt <= fifo_cnt + CNT_ONE;
         end else if (pop && !push) begin
            fifo_cnt <= fifo_cnt - CNT_ONE;
         end
      end
   end

   // Storage: payload copies, queued IDs and the held selection (no reset needed)
   always_ff @(posedge clk_i) begin
      if (issue) begin
         table_data[next_id] <= pick_data;
      end
      if (push) begin
         fifo_mem[wr_ptr] <= fb_id_i;
      end
      if (capture) begin
         held_retry <= pick_retry;
         held_id    <= pick_id;
         held_data  <= pick_data;
      end
   end

endmodule

// File: tb/tb_dmr_retry_buffer.sv
// Directed bench for dmr_retry_buffer: pass-through, retry replay, table
// full and wrap, selection lock, stale feedback and mid-flight reset.
module tb_dmr_retry_buffer;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] data_o;
   logic [3:0] id_o;
   logic       valid_o;
   logic       ready_i;
   logic       fb_valid_i;
   logic [3:0] fb_id_i;
   logic       fb_needs_retry_i;
   logic       fb_ready_o;

   int total = 0;
   int bad   = 0;

   dmr_retry_buffer #(.DataType(logic [7:0]), .IDSize(4)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .data_i           (data_i),
      .valid_i          (valid_i),
      .ready_o          (ready_o),
      .data_o           (data_o),
      .id_o             (id_o),
      .valid_o          (valid_o),
      .ready_i          (ready_i),
      .fb_valid_i       (fb_valid_i),
      .fb_id_i          (fb_id_i),
      .fb_needs_retry_i (fb_needs_retry_i),
      .fb_ready_o       (fb_ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after input changes
   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      valid_i          = 1'b0;
      data_i           = 8'h00;
      ready_i          = 1'b1;
      fb_valid_i       = 1'b0;
      fb_id_i          = 4'd0;
      fb_needs_retry_i = 1'b0;
   endtask

   task automatic reset_pulse();
      idle_inputs();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
   endtask

   initial begin
      // Reset state with upstream valid already high
      rst_ni = 1'b0;
      idle_inputs();
      valid_i = 1'b1;
      data_i  = 8'h11;
      tick();
      settle();
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_ready_o", 32'(ready_o), 32'd0);
      chk("rst_fb_ready_o", 32'(fb_ready_o), 32'd1);
      tick();
      rst_ni = 1'b1;

      // Pass-through stream with clean feedback
      data_i = 8'h11;
      settle();
      chk("pt0_valid", 32'(valid_o), 32'd1);
      chk("pt0_id", 32'(id_o), 32'd0);
      chk("pt0_data", 32'(data_o), 32'h11);
      chk("pt0_ready", 32'(ready_o), 32'd1);
      tick();
      data_i = 8'h22; fb_valid_i = 1'b1; fb_id_i = 4'd0; fb_needs_retry_i = 1'b0;
      settle();
      chk("pt1_id", 32'(id_o), 32'd1);
      chk("pt1_data", 32'(data_o), 32'h22);
      chk("pt1_ready", 32'(ready_o), 32'd1);
      tick();
      data_i = 8'h33; fb_id_i = 4'd1;
      settle();
      chk("pt2_id", 32'(id_o), 32'd2);
      chk("pt2_data", 32'(data_o), 32'h33);
      chk("pt2_ready", 32'(ready_o), 32'd1);
      tick();
      valid_i = 1'b0; fb_id_i = 4'd2;
      settle();
      chk("pt_idle_valid", 32'(valid_o), 32'd0);
      tick();

      // Retry replay
      reset_pulse();
      valid_i = 1'b1; data_i = 8'hA5;
      settle();
      chk("rt_issue_id", 32'(id_o), 32'd0);
      chk("rt_issue_ready", 32'(ready_o), 32'd1);
      tick();
      valid_i = 1'b0; fb_valid_i = 1'b1; fb_id_i = 4'd0; fb_needs_retry_i = 1'b1;
      settle();
      chk("rt_no_bypass", 32'(valid_o), 32'd0);
      tick();
      fb_valid_i = 1'b0; fb_needs_retry_i = 1'b0; valid_i = 1'b1; data_i = 8'h66;
      settle();
      chk("rt_valid", 32'(valid_o), 32'd1);
      chk("rt_id", 32'(id_o), 32'd0);
      chk("rt_data", 32'(data_o), 32'hA5);
      chk("rt_ready", 32'(ready_o), 32'd0);
      tick();
      settle();
      chk("rt_after_id", 32'(id_o), 32'd1);
      chk("rt_after_data", 32'(data_o), 32'h66);
      chk("rt_after_ready", 32'(ready_o), 32'd1);
      tick();

      // Table full, then wrap to ID 0 once it is freed
      reset_pulse();
      valid_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_i = 8'(i + 8'h40);
         settle();
         chk("full_fill_id", 32'(id_o), 32'(i));
         tick();
      end
      data_i = 8'h77;
      settle();
      chk("full_ready", 32'(ready_o), 32'd0);
      chk("full_valid", 32'(valid_o), 32'd0);
      tick();
      fb_valid_i = 1'b1; fb_id_i = 4'd0; fb_needs_retry_i = 1'b0;
      settle();
      chk("full_free_same_cycle", 32'(ready_o), 32'd0);
      tick();
      fb_valid_i = 1'b0;
      settle();
      chk("wrap_valid", 32'(valid_o), 32'd1);
      chk("wrap_id", 32'(id_o), 32'd0);
      chk("wrap_data", 32'(data_o), 32'h77);
      chk("wrap_ready", 32'(ready_o), 32'd1);
      tick();

      // Selection lock: a held new transaction is not pre-empted by a retry
      reset_pulse();
      valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_i = 8'(i);
         tick();
      end
      data_i = 8'h5A; ready_i = 1'b0;
      settle();
      chk("lk_valid", 32'(valid_o), 32'd1);
      chk("lk_id", 32'(id_o), 32'd4);
      chk("lk_ready", 32'(ready_o), 32'd0);
      tick();
      fb_valid_i = 1'b1; fb_id_i = 4'd3; fb_needs_retry_i = 1'b1;
      settle();
      chk("lk_hold1_id", 32'(id_o), 32'd4);
      chk("lk_hold1_data", 32'(data_o), 32'h5A);
      tick();
      fb_valid_i = 1'b0; fb_needs_retry_i = 1'b0;
      settle();
      chk("lk_hold2_id", 32'(id_o), 32'd4);
      chk("lk_hold2_data", 32'(data_o), 32'h5A);
      tick();
      ready_i = 1'b1;
      settle();
      chk("lk_accept_id", 32'(id_o), 32'd4);
      chk("lk_accept_ready", 32'(ready_o), 32'd1);
      tick();
      data_i = 8'h99;
      settle();
      chk("lk_retry_id", 32'(id_o), 32'd3);
      chk("lk_retry_data", 32'(data_o), 32'h03);
      chk("lk_retry_ready", 32'(ready_o), 32'd0);
      tick();
      settle();
      chk("lk_next_id", 32'(id_o), 32'd5);
      chk("lk_next_data", 32'(data_o), 32'h99);
      tick();
      valid_i = 1'b0;

      // Stale feedback for an ID that is not in flight
      fb_valid_i = 1'b1; fb_id_i = 4'd7; fb_needs_retry_i = 1'b1;
      tick();
      fb_valid_i = 1'b0; fb_needs_retry_i = 1'b0;
      settle();
      chk("stale_valid", 32'(valid_o), 32'd0);
      valid_i = 1'b1; data_i = 8'hE1; ready_i = 1'b0;
      settle();
      chk("stale_new_id", 32'(id_o), 32'd6);
      chk("stale_new_data", 32'(data_o), 32'hE1);
      valid_i = 1'b0; ready_i = 1'b1;
      tick();

      // Reset with several IDs busy and one queued for retry
      ready_i = 1'b0; fb_valid_i = 1'b1; fb_id_i = 4'd2; fb_needs_retry_i = 1'b1;
      tick();
      fb_valid_i = 1'b0; fb_needs_retry_i = 1'b0;
      settle();
      chk("rq_queued_id", 32'(id_o), 32'd2);
      chk("rq_queued_valid", 32'(valid_o), 32'd1);
      rst_ni = 1'b0;
      #2;
      chk("rq_reset_valid", 32'(valid_o), 32'd0);
      chk("rq_reset_ready", 32'(ready_o), 32'd0);
      tick();
      rst_ni = 1'b1; ready_i = 1'b1;
      settle();
      chk("rq_post_idle", 32'(valid_o), 32'd0);
      valid_i = 1'b1; data_i = 8'hC3;
      settle();
      chk("rq_post_valid", 32'(valid_o), 32'd1);
      chk("rq_post_id", 32'(id_o), 32'd0);
      chk("rq_post_data", 32'(data_o), 32'hC3);
      chk("rq_post_ready", 32'(ready_o), 32'd1);
      tick();
      valid_i = 1'b0;
      settle();
      chk("rq_end_valid", 32'(valid_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
